// File: rtl/nfc_irq_pkg.sv
// Shared register map, field positions and widths for the NFC IRQ conditioner.
package nfc_irq_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h04;
    localparam logic [7:0] ADDR_TMO_LOAD = 8'h08;
    localparam logic [7:0] ADDR_EDGE_CNT = 8'h0C;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE_IRQ = 1;
    localparam int CTRL_IE_TMO = 2;
    localparam int CTRL_ARM    = 3;
    localparam int CTRL_LVL    = 4;

    localparam int ST_IRQ_PEND = 0;
    localparam int ST_TMO_PEND = 1;
    localparam int ST_LEVEL    = 2;
    localparam int ST_ARMED    = 3;

    localparam int EDGE_CNT_W = 16;
    localparam int FILT_CNT_W = 8;

    // Word index of a byte address; the two low address bits are don't-care.
    function automatic logic [5:0] word_of(input logic [7:0] addr);
        return addr[7:2];
    endfunction

endpackage

// File: rtl/nfc_irq_filter.sv
// Two-flop synchroniser plus stability filter for the active-low NFC IRQ pin.
module nfc_irq_filter
    import nfc_irq_pkg::*;
#(
    parameter int FILT_CYC = 8
) (
    input  logic pclk,
    input  logic nreset,
    input  logic irq_pin,
    output logic level,
    output logic fall,
    output logic rise
);

    logic                  sync_p0;
    logic                  sync_p1;
    logic [FILT_CNT_W-1:0] cnt;
    logic                  hit;

    // The level flips on the same edge that the counter would reach FILT_CYC.
    assign hit  = (sync_p1 != level) && (cnt == FILT_CNT_W'(FILT_CYC - 1));
    assign fall = hit & level;
    assign rise = hit & ~level;

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
        end else begin
            sync_p0 <= irq_pin;
            sync_p1 <= sync_p0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (hit) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + FILT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nfc_irq_ctrl.sv
// APB3 interrupt conditioner for the NFC IRQ line: status, timeout timer, fabint.
// Optional level-sensitive IRQ_PEND mode is built when NFC_IRQ_LEVEL_MODE_EN is defined.
module nfc_irq_ctrl
    import nfc_irq_pkg::*;
#(
    parameter int FILT_CYC = 8,
    parameter int TMO_W    = 24
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        irq_pin,
    output logic        fabint
);

    logic                  en, ie_irq, ie_tmo, lvl;
    logic                  irq_pend, tmo_pend, armed;
    logic [TMO_W-1:0]      tmo_load, tmo_cnt;
    logic [EDGE_CNT_W-1:0] edge_cnt;
    logic                  level, fall, rise;
    logic [5:0]            widx;
    logic                  addr_ok, acc, wr;
    logic                  wr_ctrl, wr_status, wr_tmo, wr_edge;
    logic                  arm_wr, edge_ev, tmo_exp, lvl_act;
    logic                  unused_bits;

    nfc_irq_filter #(.FILT_CYC(FILT_CYC)) u_filter (
        .pclk    (pclk),
        .nreset  (nreset),
        .irq_pin (irq_pin),
        .level   (level),
        .fall    (fall),
        .rise    (rise)
    );

    assign widx      = paddr[7:2];
    assign addr_ok   = widx <= word_of(ADDR_EDGE_CNT);
    assign acc       = psel & penable;
    assign wr        = acc & pwrite & addr_ok;
    assign pready    = 1'b1;
    assign pslverr   = acc & ~addr_ok;
    assign wr_ctrl   = wr & (widx == word_of(ADDR_CTRL));
    assign wr_status = wr & (widx == word_of(ADDR_STATUS));
    assign wr_tmo    = wr & (widx == word_of(ADDR_TMO_LOAD));
    assign wr_edge   = wr & (widx == word_of(ADDR_EDGE_CNT));

    assign arm_wr  = wr_ctrl & pwdata[CTRL_ARM] & en;
    assign edge_ev = en & fall;
    // An edge or a re-arm in the same cycle pre-empts expiry.
    assign tmo_exp = en & armed & ~arm_wr & ~fall & (tmo_cnt == '0);
    assign lvl_act = en & lvl;

    assign unused_bits = ^{paddr[1:0], pwdata};

`ifdef NFC_IRQ_LEVEL_MODE_EN
    always_ff @(posedge pclk) begin
        if (!nreset)      lvl <= 1'b0;
        else if (wr_ctrl) lvl <= pwdata[CTRL_LVL];
    end
`else
    assign lvl = 1'b0;
`endif

    always_comb begin
        prdata = '0;
        if (psel && addr_ok) begin
            case (widx)
                word_of(ADDR_CTRL): begin
                    prdata[CTRL_EN]     = en;
                    prdata[CTRL_IE_IRQ] = ie_irq;
                    prdata[CTRL_IE_TMO] = ie_tmo;
                    prdata[CTRL_LVL]    = lvl;
                end
                word_of(ADDR_STATUS): begin
                    prdata[ST_IRQ_PEND] = irq_pend;
                    prdata[ST_TMO_PEND] = tmo_pend;
                    prdata[ST_LEVEL]    = level;
                    prdata[ST_ARMED]    = armed;
                end
                word_of(ADDR_TMO_LOAD): prdata[TMO_W-1:0]      = tmo_load;
                default:                prdata[EDGE_CNT_W-1:0] = edge_cnt;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            en       <= 1'b0;
            ie_irq   <= 1'b0;
            ie_tmo   <= 1'b0;
            irq_pend <= 1'b0;
            tmo_pend <= 1'b0;
            armed    <= 1'b0;
            tmo_load <= '0;
            tmo_cnt  <= '0;
            edge_cnt <= '0;
            fabint   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en     <= pwdata[CTRL_EN];
                ie_irq <= pwdata[CTRL_IE_IRQ];
                ie_tmo <= pwdata[CTRL_IE_TMO];
            end
            if (wr_tmo) tmo_load <= pwdata[TMO_W-1:0];

            // Level mode tracks the filter's next level so it aligns with edge mode.
            if (lvl_act) irq_pend <= fall | (~rise & ~level);
            else         irq_pend <= edge_ev | (irq_pend & ~(wr_status & pwdata[ST_IRQ_PEND]));
            tmo_pend <= tmo_exp | (tmo_pend & ~(wr_status & pwdata[ST_TMO_PEND]));

            if (wr_edge)      edge_cnt <= EDGE_CNT_W'(edge_ev);
            else if (edge_ev) edge_cnt <= edge_cnt + EDGE_CNT_W'(1);

            if (!en) begin
                armed <= 1'b0;
            end else if (arm_wr) begin
                tmo_cnt <= tmo_load;
                armed   <= 1'b1;
            end else if (fall) begin
                armed <= 1'b0;
            end else if (armed) begin
                if (tmo_cnt == '0) armed   <= 1'b0;
                else               tmo_cnt <= tmo_cnt - TMO_W'(1);
            end

            fabint <= en & ((irq_pend & ie_irq) | (tmo_pend & ie_tmo));
        end
    end

endmodule

// File: tb/tb_nfc_irq_ctrl.sv
// Directed bench for nfc_irq_ctrl with hand-computed expectations (FILT_CYC=8).
module tb_nfc_irq_ctrl;
    import nfc_irq_pkg::*;

    logic        pclk    = 1'b0;
    logic        nreset  = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [7:0]  paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq_pin = 1'b1;
    logic        fabint;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    nfc_irq_ctrl #(.FILT_CYC(8), .TMO_W(24)) dut (
        .pclk    (pclk),
        .nreset  (nreset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq_pin (irq_pin),
        .fabint  (fabint)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic e;
        apb_wr(a, d, e);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd(a, d, e);
        check(tag, d, exp);
    endtask

    // Counts posedges until fabint reaches the wanted value, bounded by maxc.
    task automatic wait_fab(input logic want, input int maxc, output int cyc);
        cyc = 0;
        while (fabint !== want && cyc < maxc) begin
            @(negedge pclk);
            cyc++;
        end
    endtask

    task automatic pin_pulse(input int low_cyc);
        @(negedge pclk);
        irq_pin = 1'b0;
        cycles(low_cyc);
        irq_pin = 1'b1;
        cycles(15);
    endtask

    initial begin
        int          c;
        logic [31:0] d;
        logic        e;

        cycles(3);
        nreset = 1'b1;
        cycles(1);
        check("rst_fabint", fabint, 0);
        check("idle_prdata", prdata, 0);
        check("idle_pslverr", pslverr, 0);
        rd_chk("rst_ctrl", ADDR_CTRL, 32'h0);
        rd_chk("rst_status", ADDR_STATUS, 32'h4);
        rd_chk("rst_tmo_load", ADDR_TMO_LOAD, 32'h0);
        rd_chk("rst_edge_cnt", ADDR_EDGE_CNT, 32'h0);

        // Short glitch must be filtered out
        wr(ADDR_CTRL, 32'h3);
        @(negedge pclk);
        irq_pin = 1'b0;
        cycles(5);
        irq_pin = 1'b1;
        cycles(20);
        check("glitch_fabint", fabint, 0);
        rd_chk("glitch_status", ADDR_STATUS, 32'h4);
        rd_chk("glitch_edge_cnt", ADDR_EDGE_CNT, 32'h0);

        // Real falling edge: IRQ_PEND at edge 10, fabint at edge 11
        @(negedge pclk);
        irq_pin = 1'b0;
        wait_fab(1'b1, 40, c);
        check("irq_latency", c, 11);
        cycles(9);
        irq_pin = 1'b1;
        cycles(15);
        rd_chk("irq_status", ADDR_STATUS, 32'h5);
        rd_chk("irq_edge_cnt", ADDR_EDGE_CNT, 32'h1);
        wr(ADDR_STATUS, 32'h1);
        check("w1c_fab_hold", fabint, 1);
        cycles(1);
        check("w1c_fab_clr", fabint, 0);

        // Timeout: ARM at edge P, TMO_PEND at P+101, fabint at P+102
        wr(ADDR_TMO_LOAD, 32'd100);
        wr(ADDR_CTRL, 32'h7);
        wr(ADDR_CTRL, 32'hF);
        wait_fab(1'b1, 200, c);
        check("tmo_latency", c, 102);
        rd_chk("tmo_status", ADDR_STATUS, 32'h6);
        rd_chk("ctrl_arm_reads0", ADDR_CTRL, 32'h7);
        wr(ADDR_STATUS, 32'h2);

        // Edge while armed disarms; no timeout follows
        wr(ADDR_CTRL, 32'hF);
        rd_chk("armed_status", ADDR_STATUS, 32'hC);
        cycles(40);
        pin_pulse(15);
        cycles(100);
        rd_chk("edge_disarm_status", ADDR_STATUS, 32'h5);
        rd_chk("edge_disarm_cnt", ADDR_EDGE_CNT, 32'h2);
        wr(ADDR_STATUS, 32'h1);

        // Filtered edge lands on the W1C write edge: set wins
        @(negedge pclk);
        irq_pin = 1'b0;
        cycles(7);
        wr(ADDR_STATUS, 32'h1);
        cycles(5);
        irq_pin = 1'b1;
        cycles(15);
        rd_chk("set_wins_status", ADDR_STATUS, 32'h5);
        rd_chk("set_wins_cnt", ADDR_EDGE_CNT, 32'h3);
        wr(ADDR_STATUS, 32'h1);

        // TMO_LOAD=0: TMO_PEND one edge after ARM
        wr(ADDR_TMO_LOAD, 32'd0);
        wr(ADDR_CTRL, 32'hF);
        check("tmo0_fab_p0", fabint, 0);
        cycles(1);
        check("tmo0_fab_p1", fabint, 0);
        cycles(1);
        check("tmo0_fab_p2", fabint, 1);
        rd_chk("tmo0_status", ADDR_STATUS, 32'h6);
        wr(ADDR_STATUS, 32'h3);

        // Unmapped accesses
        apb_rd(8'h10, d, e);
        check("bad_rd_err", e, 1);
        check("bad_rd_data", d, 0);
        apb_wr(8'h40, 32'hFFFF_FFFF, e);
        check("bad_wr_err", e, 1);
        apb_rd(ADDR_CTRL, d, e);
        check("good_rd_err", e, 0);
        check("bad_wr_ctrl", d, 32'h7);
        rd_chk("bad_wr_tmo", ADDR_TMO_LOAD, 32'h0);
        rd_chk("bad_wr_status", ADDR_STATUS, 32'h4);

        // EN=0 while armed: disarm, keep pending, ignore ARM and edges
        pin_pulse(15);
        wr(ADDR_TMO_LOAD, 32'd1000);
        wr(ADDR_CTRL, 32'hF);
        rd_chk("en_armed_status", ADDR_STATUS, 32'hD);
        wr(ADDR_CTRL, 32'h6);
        rd_chk("en0_status", ADDR_STATUS, 32'h5);
        check("en0_fabint", fabint, 0);
        wr(ADDR_CTRL, 32'hE);
        rd_chk("en0_arm_ignored", ADDR_STATUS, 32'h5);
        pin_pulse(15);
        rd_chk("en0_edge_cnt", ADDR_EDGE_CNT, 32'h4);
        wr(ADDR_EDGE_CNT, 32'h0);
        rd_chk("edge_cnt_clear", ADDR_EDGE_CNT, 32'h0);

        // Reset mid-operation
        wr(ADDR_CTRL, 32'h7);
        wr(ADDR_TMO_LOAD, 32'd55);
        cycles(2);
        check("pre_reset_fabint", fabint, 1);
        @(negedge pclk);
        nreset = 1'b0;
        @(negedge pclk);
        nreset = 1'b1;
        check("mid_rst_fabint", fabint, 0);
        rd_chk("mid_rst_ctrl", ADDR_CTRL, 32'h0);
        rd_chk("mid_rst_status", ADDR_STATUS, 32'h4);
        rd_chk("mid_rst_tmo", ADDR_TMO_LOAD, 32'h0);

`ifdef NFC_IRQ_LEVEL_MODE_EN
        // Level mode: IRQ_PEND follows the inverted filtered level
        wr(ADDR_CTRL, 32'h13);
        rd_chk("lvl_ctrl", ADDR_CTRL, 32'h13);
        @(negedge pclk);
        irq_pin = 1'b0;
        cycles(15);
        rd_chk("lvl_status_low", ADDR_STATUS, 32'h1);
        wr(ADDR_STATUS, 32'h1);
        rd_chk("lvl_w1c_ignored", ADDR_STATUS, 32'h1);
        check("lvl_fabint", fabint, 1);
        @(negedge pclk);
        irq_pin = 1'b1;
        wait_fab(1'b0, 40, c);
        check("lvl_release_latency", c, 11);
`else
        // Without level mode, CTRL b4 is not writable
        wr(ADDR_CTRL, 32'h13);
        rd_chk("no_lvl_ctrl", ADDR_CTRL, 32'h3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nfc_irq_ctrl.md
Name: nfc_irq_ctrl

Overview:
APB3-slave interrupt conditioner for the NFC reader's active-low IRQ line. It feeds the MSS fabric interrupt.
- Synchronises and glitch-filters irq_pin.
- Latches falling edges as a pending status.
- Runs a response-timeout timer armed by firmware.
- Drives a registered fabint to the MSS from masked pending flags.

Parameters:
FILT_CYC, 8, consecutive stable cycles needed before the filtered level changes (1..255).
TMO_W, 24, width of the timeout counter and TMO_LOAD register.

Ports:
pclk  in  1  APB/fabric clock.
nreset  in  1  Reset, synchronous, active-low.
psel  in  1  APB select.
penable  in  1  APB access phase.
pwrite  in  1  APB write.
paddr  in  8  Byte address; bits [1:0] ignored.
pwdata  in  32  Write data.
prdata  out  32  Read data.
pready  out  1  Tied 1 (zero wait states).
pslverr  out  1  Error on unmapped access.
irq_pin  in  1  Asynchronous active-low IRQ from the NFC chip.
fabint  out  1  Active-high interrupt to the MSS.

Behaviour:
- Reset values:
  - All registers 0, except sync flops and filtered level, which reset to 1 (idle high).
  - fabint = 0, prdata = 0, pslverr = 0, edge counter = 0.
- Register map:
  - 0x00 CTRL (RW):
    - b0 EN
    - b1 IE_IRQ
    - b2 IE_TMO
    - b3 ARM: write-1 action, reads 0.
  - 0x04 STATUS:
    - b0 IRQ_PEND (W1C)
    - b1 TMO_PEND (W1C)
    - b2 filtered irq level (RO)
    - b3 ARMED (RO)
  - 0x08 TMO_LOAD (RW), [TMO_W-1:0]; upper bits read 0.
  - 0x0C EDGE_CNT (RO), [15:0]; wraps 0xFFFF->0; any write clears it.
- APB:
  - Writes take effect on the psel&penable&pwrite cycle.
  - prdata is combinational from registers during psel; 0 otherwise.
  - paddr > 0x0C: pslverr = 1 in the access phase, no state change, prdata = 0.
- Synchroniser: 2 flops.
- Filter:
  - Counter increments while the synced value differs from the filtered level; it clears when they are equal.
  - When the counter reaches FILT_CYC, the filtered level takes the synced value and the counter clears.
  - Total input-to-filtered latency is FILT_CYC+2 cycles.
  - The filter runs regardless of EN.
- Edge detect: a filtered 1->0 transition with EN=1 causes, in the same cycle:
  - IRQ_PEND set;
  - EDGE_CNT++;
  - ARMED cleared (timer stopped).
  - A 0->1 transition has no effect.
- Timer:
  - Writing ARM=1 with EN=1 loads the counter from TMO_LOAD and sets ARMED.
  - Counter decrements each cycle while ARMED.
  - Counter==0 while ARMED: set TMO_PEND, clear ARMED.
  - TMO_LOAD=0: TMO_PEND is set the cycle after ARM.
  - Re-ARM while ARMED reloads the counter.
  - An ARM write with EN=0 is ignored.
- EN=0: edges are ignored and ARMED is cleared. Pending flags and EDGE_CNT are retained.
- Simultaneous events:
  - Hardware set and W1C of the same bit in one cycle: the set wins.
  - Edge and timer expiry in one cycle: the edge wins; TMO_PEND is not set.
  - ARM write and edge in one cycle: ARM wins (timer reloaded, ARMED=1); IRQ_PEND still set.
- fabint is registered: fabint <= EN & ((IRQ_PEND & IE_IRQ) | (TMO_PEND & IE_TMO)). It follows a flag change by 1 cycle.
- Synchronous reset mid-operation returns everything to reset values on the next edge. The filtered level restarts at 1, so a pin held low produces one edge FILT_CYC+2 cycles after reset release once EN is set — but only if EN is set before the filter settles.

Optional Feature:
NFC_IRQ_LEVEL_MODE_EN:
- Defined: CTRL b4 LVL is added (RW, reset 0). With LVL=1 and EN=1, IRQ_PEND mirrors the inverted filtered level each cycle and W1C has no effect. EDGE_CNT and timer disarm still act on falling edges.
- Undefined: b4 reads 0, writes are ignored, and edge mode is the only mode.

Decomposition:
- Package nfc_irq_pkg holds:
  - Address offsets: ADDR_CTRL, ADDR_STATUS, ADDR_TMO_LOAD, ADDR_EDGE_CNT.
  - Bit-index constants for CTRL and STATUS fields.
  - EDGE_CNT_W = 16.
- Sub-module nfc_irq_filter (sync + glitch filter, parameter FILT_CYC) outputs the filtered level and a one-cycle fall pulse.
- The top holds the APB decode, registers, timer and fabint.

Test Plan:
- Reset, read all four registers -> CTRL=0, STATUS=0x4, TMO_LOAD=0, EDGE_CNT=0; fabint=0.
- EN=1, IE_IRQ=1; irq_pin low 5 cycles then high -> no IRQ_PEND, fabint stays 0. irq_pin low 20 cycles -> IRQ_PEND=1 at cycle 10, fabint=1 at cycle 11, EDGE_CNT=1. W1C 0x1 to STATUS -> fabint=0 next cycle.
- TMO_LOAD=100, IE_TMO=1, ARM, no pin activity -> TMO_PEND=1 and ARMED=0 ~100 cycles later, fabint one cycle after. Repeat with an irq edge at cycle 50 -> ARMED=0, TMO_PEND stays 0.
- Edge pulse aligned to the W1C-of-IRQ_PEND access cycle -> IRQ_PEND remains 1. TMO_LOAD=0 + ARM -> TMO_PEND the next cycle.
- Read 0x10 and write 0x40 -> pslverr=1, prdata=0, no register changes. EN=0 during ARMED -> ARMED=0, pending bits kept.
- With NFC_IRQ_LEVEL_MODE_EN, LVL=1: hold pin low -> IRQ_PEND=1 persists through a W1C; release -> IRQ_PEND=0 FILT_CYC+2 cycles later.
